// File: rtl/rca_pkg.sv
// rca_pkg
// Shared constants and helpers for the pipelined ripple-carry adder.
//   DEFAULT_WIDTH / DEFAULT_CHUNK : default operand width and bits per stage
//   stages()                      : number of pipeline stages (= latency)
//   width_ok()                    : true when WIDTH splits evenly into CHUNKs
package rca_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder cell used as the building block of every ripple slice.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// rca_chunk
// Combinational CHUNK-bit ripple adder made of full_adder cells.
//   a, b  : CHUNK-bit slices of the operands
//   cin   : carry into bit 0
//   s     : CHUNK-bit sum
//   cout  : carry out of the MSB
//   cmsb  : carry into the MSB (paired with cout to detect signed overflow)
module rca_chunk
    import rca_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (s[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[CHUNK];
    assign cmsb = carry[CHUNK-1];

endmodule

// File: rtl/rca_pipelined.sv
// rca_pipelined
// Pipelined ripple-carry adder/subtractor. Each CHUNK-bit slice of the
// operation is resolved in its own stage, so one operation is accepted per
// enabled cycle and its result appears STAGES enabled edges later.
//   clk       : clock, rising edge
//   reset     : synchronous active-high, clears all pipeline state
//   enable    : 1 advances the pipeline, 0 holds every register
//   valid_in  : qualifies A, B, Cin, sub
//   A, B      : WIDTH-bit operands
//   Cin       : carry in (add mode only)
//   sub       : 0 = A + B + Cin, 1 = A - B
//   Q         : {carry out, WIDTH-bit result}
//   valid_out : one-cycle pulse when Q/overflow carry a new result
//   overflow  : two's-complement overflow of the WIDTH-bit result
module rca_pipelined
    import rca_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic [WIDTH:0]   Q,
    output logic             valid_out,
    output logic             overflow
);

    localparam int STAGES = stages(WIDTH, CHUNK);

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("rca_pipelined: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Subtraction is A + ~B + 1, so B is inverted once at the entry and the
    // forced carry-in provides the +1.
    logic [WIDTH-1:0] b_eff;
    assign b_eff = sub ? ~B : B;

    logic             cmsb_last;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_cout;
    logic             fin_ovf;
    logic             fin_valid;

    // Stage k sees the operand bits from chunk k upwards (a_op/b_op), the
    // carry from stage k-1 and the low sum chunks already finished. Stage 0
    // takes these straight from the inputs; later stages own a register that
    // captures the previous stage's results, which forms the operand skew.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int OPW = WIDTH - k * CHUNK;

        logic [OPW-1:0]         a_op;
        logic [OPW-1:0]         b_op;
        logic                   c_op;
        logic                   v_op;
        logic [CHUNK-1:0]       s_c;
        logic                   cout_c;
        logic [(k+1)*CHUNK-1:0] sum_all;

        if (k == 0) begin : g_head
            assign a_op    = A;
            assign b_op    = b_eff;
            assign c_op    = sub | Cin;
            assign v_op    = valid_in;
            assign sum_all = s_c;
        end else begin : g_reg
            localparam int PREV_OPW = WIDTH - (k - 1) * CHUNK;

            logic [k*CHUNK-1:0] sum_q;

            // Stage register: moves the previous stage's carry, finished sum
            // chunks and still-pending operand chunks one step down the pipe.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_op  <= 1'b0;
                    c_op  <= 1'b0;
                    a_op  <= '0;
                    b_op  <= '0;
                    sum_q <= '0;
                end else if (enable) begin
                    v_op  <= g_stage[k-1].v_op;
                    c_op  <= g_stage[k-1].cout_c;
                    a_op  <= g_stage[k-1].a_op[PREV_OPW-1:CHUNK];
                    b_op  <= g_stage[k-1].b_op[PREV_OPW-1:CHUNK];
                    sum_q <= g_stage[k-1].sum_all;
                end
            end

            assign sum_all = {s_c, sum_q};
        end

        if (k == STAGES - 1) begin : g_last
            rca_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a   (a_op[CHUNK-1:0]),
                .b   (b_op[CHUNK-1:0]),
                .cin (c_op),
                .s   (s_c),
                .cout(cout_c),
                .cmsb(cmsb_last)
            );
        end else begin : g_mid
            logic cmsb_unused;

            rca_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a   (a_op[CHUNK-1:0]),
                .b   (b_op[CHUNK-1:0]),
                .cin (c_op),
                .s   (s_c),
                .cout(cout_c),
                .cmsb(cmsb_unused)
            );
        end
    end

    // Register after the last slice; overflow is resolved here because only
    // the top slice knows both the carry into and out of the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            fin_valid <= 1'b0;
            fin_sum   <= '0;
            fin_cout  <= 1'b0;
            fin_ovf   <= 1'b0;
        end else if (enable) begin
            fin_valid <= g_stage[STAGES-1].v_op;
            fin_sum   <= g_stage[STAGES-1].sum_all;
            fin_cout  <= g_stage[STAGES-1].cout_c;
            fin_ovf   <= cmsb_last ^ g_stage[STAGES-1].cout_c;
        end
    end

    // Output registers only take real results; bubbles and stalls leave the
    // last result visible, and valid_out pulses once per delivered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q         <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= enable & fin_valid;
            if (enable && fin_valid) begin
                Q        <= {fin_cout, fin_sum};
                overflow <= fin_ovf;
            end
        end
    end

endmodule

// File: tb/tb_rca_pipelined.sv
// tb_rca_pipelined
// Scoreboard bench for rca_pipelined (WIDTH 16, CHUNK 4). The driver pushes
// each expected result with the edge it must appear on; the monitor pops and
// compares whenever valid_out is seen, and otherwise checks that Q holds.
module tb_rca_pipelined;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    typedef struct {
        logic [WIDTH:0] q;
        logic           ovf;
        int             when;
    } sbEntry_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b1;
    logic             validIn = 1'b0;
    logic [WIDTH-1:0] opA = '0;
    logic [WIDTH-1:0] opB = '0;
    logic             cin = 1'b0;
    logic             subMode = 1'b0;
    logic [WIDTH:0]   q;
    logic             validOut;
    logic             overflow;

    sbEntry_t         sb[$];
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH:0]   holdQ = '0;
    logic             holdOvf = 1'b0;

    rca_pipelined #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .valid_in (validIn),
        .A        (opA),
        .B        (opB),
        .Cin      (cin),
        .sub      (subMode),
        .Q        (q),
        .valid_out(validOut),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, want);
        end
    endtask

    // Issue one operation; it is sampled on the next edge and must come back
    // lat edges after that.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s,
                                 input logic [WIDTH:0] expQ, input logic expOvf, input int lat);
        sbEntry_t ent;
        @(posedge clk);
        #2;
        enable  = 1'b1;
        validIn = 1'b1;
        opA     = a;
        opB     = b;
        cin     = c;
        subMode = s;
        ent.q    = expQ;
        ent.ovf  = expOvf;
        ent.when = cyc + 1 + lat;
        sb.push_back(ent);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            enable  = 1'b1;
            validIn = 1'b0;
            opA     = 16'h5A5A;
            opB     = 16'hA5A5;
        end
    endtask

    // Inputs are don't-care while stalled, so drive live-looking garbage.
    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            enable  = 1'b0;
            validIn = 1'b1;
            opA     = 16'(($urandom));
            opB     = 16'(($urandom));
            cin     = 1'($urandom);
            subMode = 1'($urandom);
        end
    endtask

    // One-cycle reset with enable low, so reset must win over the stall.
    task automatic pulseReset();
        @(posedge clk);
        #2;
        reset   = 1'b1;
        enable  = 1'b0;
        validIn = 1'b1;
        opA     = 16'h0F0F;
        opB     = 16'h0101;
        @(posedge clk);
        #2;
        reset   = 1'b0;
        enable  = 1'b1;
        validIn = 1'b0;
        sb.delete();
        holdQ   = '0;
        holdOvf = 1'b0;
    endtask

    // Monitor: every delivered result must be the next scoreboard entry, on
    // its edge; between results Q and overflow must hold.
    always @(negedge clk) begin
        sbEntry_t ent;
        if (validOut === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid_out at edge %0d: got Q=0x%0h, expected no result", cyc, q);
            end else begin
                ent = sb.pop_front();
                checkOutput("result_q", 32'(q), 32'(ent.q));
                checkOutput("result_ovf", 32'(overflow), 32'(ent.ovf));
                checkOutput("result_edge", cyc, ent.when);
                holdQ   = ent.q;
                holdOvf = ent.ovf;
            end
        end else begin
            checkOutput("valid_out_low", 32'(validOut), 32'd0);
            checkOutput("hold_q", 32'(q), 32'(holdQ));
            checkOutput("hold_ovf", 32'(overflow), 32'(holdOvf));
        end
    end

    initial begin
        $display("[TB] rca_pipelined bench start");
        // Two reset cycles with enable high.
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_valid_out", 32'(validOut), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);

        // Directed arithmetic, streamed back to back.
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 4);
        idle(4);
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0, 17'h08000, 1'b1, 4);
        applyStimulus(16'h0003, 16'h0005, 1'b1, 1'b1, 17'h0FFFE, 1'b0, 4);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1, 4);
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0, 4);
        applyStimulus(16'h0005, 16'h0003, 1'b0, 1'b1, 17'h10002, 1'b0, 4);
        applyStimulus(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 17'h0FFFE, 1'b1, 4);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1, 4);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b0, 4);
        applyStimulus(16'h0FFF, 16'h0001, 1'b0, 1'b0, 17'h01000, 1'b0, 4);
        idle(6);

        // Stream of four with a 3-cycle stall after the third.
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002, 1'b0, 7);
        applyStimulus(16'h0002, 16'h0002, 1'b0, 1'b0, 17'h00004, 1'b0, 7);
        applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0, 17'h00006, 1'b0, 7);
        stall(3);
        applyStimulus(16'h0004, 16'h0004, 1'b0, 1'b0, 17'h00008, 1'b0, 4);
        idle(6);

        // Stall while the result sits in the final stage.
        applyStimulus(16'h00AA, 16'h0055, 1'b0, 1'b0, 17'h000FF, 1'b0, 6);
        idle(3);
        stall(2);
        idle(4);

        // Reset with three operations in flight: none may surface.
        applyStimulus(16'h1000, 16'h2000, 1'b0, 1'b0, 17'h03000, 1'b0, 4);
        applyStimulus(16'h4000, 16'h0001, 1'b0, 1'b0, 17'h04001, 1'b0, 4);
        applyStimulus(16'h0008, 16'h0007, 1'b0, 1'b1, 17'h10001, 1'b0, 4);
        pulseReset();
        idle(6);
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 17'h03333, 1'b0, 4);

        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
